spi_wb_bridge: RTL and testbench

//  Bus-master stage directly downstream of the SPI slave command decoder.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_req_buf.sv | 35 +++
 rtl/spi_wb_bridge.sv | 136 +++++++++++++
 tb/tb_spi_wb_bridge.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI opcodes, request type and bridge state encoding
package spi_pkg;

  localparam logic [7:0] OP_READ_ID      = 8'h90;
  localparam logic [7:0] OP_READ_STATUS  = 8'h05;
  localparam logic [7:0] OP_WRITE_STATUS = 8'h01;
  localparam logic [7:0] OP_READ         = 8'h0B;
  localparam logic [7:0] OP_WRITE        = 8'h02;
  localparam logic [7:0] OP_PD           = 8'hB9;
  localparam logic [7:0] OP_EXIT_PD      = 8'hAB;
  localparam logic [7:0] OP_ARM_RST      = 8'h66;
  localparam logic [7:0] OP_FIRE_RST     = 8'h99;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [23:0] adr;
    logic [31:0] dat;
  } spi_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/spi_req_buf.sv
// rtl/spi_req_buf.sv - one-entry request holding register with store/take/overflow
module spi_req_buf
  import spi_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_store,
  input  logic     i_take,
  input  spi_req_t i_req,
  output spi_req_t o_req,
  output logic     o_full,
  output logic     o_ovf
);

  spi_req_t r_req;
  logic     r_full;

  // A take in the same cycle frees the slot, so a simultaneous store is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req  <= '0;
      r_full <= 1'b0;
    end else if (i_store && (!r_full || i_take)) begin
      r_req  <= i_req;
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_req  = r_req;
  assign o_full = r_full;
  assign o_ovf  = i_store & r_full & ~i_take;

endmodule

// File: rtl/spi_wb_bridge.sv
// rtl/spi_wb_bridge.sv - turns SPI decoder request pulses into Wishbone-classic cycles
module spi_wb_bridge
  import spi_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  input  logic        i_req_we,
  input  logic [23:0] i_req_adr,
  input  logic [31:0] i_req_dat,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [23:0] o_wb_adr,
  output logic [31:0] o_wb_dat_o,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat_i,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_err_clr,
  output logic        o_bus_err,
  output logic        o_req_ovf,
  output logic        o_busy
);

  localparam int         TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUS  = ST_BUS;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic          r_cyc, r_we, r_rsp_vld, r_bus_err, r_req_ovf;
  logic [23:0]   r_adr;
  logic [31:0]   r_dat_o, r_rsp_dat;

  spi_req_t w_new_req, w_buf_req, w_disp_req;
  logic     w_buf_full, w_buf_ovf, w_idle, w_take, w_store, w_dispatch;
  logic     w_tmo_hit, w_fail, w_term;

  assign w_new_req  = '{we: i_req_we, adr: i_req_adr, dat: i_req_dat};
  assign w_idle     = (r_state == S_IDLE);
  assign w_take     = w_idle & w_buf_full;
  assign w_dispatch = w_idle & (w_buf_full | i_req_vld);
  assign w_store    = i_req_vld & ~(w_idle & ~w_buf_full);
  assign w_disp_req = w_buf_full ? w_buf_req : w_new_req;

  // err beats a simultaneous ack; an ack landing on the last timeout cycle still wins.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_fail    = i_wb_err | (w_tmo_hit & ~i_wb_ack);
  assign w_term    = (r_state == S_BUS) & (i_wb_ack | w_fail);

  spi_req_buf u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_store (w_store),
    .i_take  (w_take),
    .i_req   (w_new_req),
    .o_req   (w_buf_req),
    .o_full  (w_buf_full),
    .o_ovf   (w_buf_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat_o   <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_dispatch) begin
          r_cyc   <= 1'b1;
          r_we    <= w_disp_req.we;
          r_adr   <= w_disp_req.adr;
          r_dat_o <= w_disp_req.dat;
          r_tmo   <= '0;
          r_state <= S_BUS;
        end
        S_BUS: if (w_term) begin
          r_cyc <= 1'b0;
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_rsp_vld <= 1'b1;
            r_rsp_dat <= w_fail ? ERR_DATA : i_wb_dat_i;
            r_state   <= S_RESP;
          end
        end else if (r_tmo < TW'(TIMEOUT_CYC)) begin
          r_tmo <= r_tmo + 1'b1;
        end
        S_RESP: if (i_rsp_rdy) begin
          r_rsp_vld <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Set has priority over err_clr so no event is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_err <= 1'b0;
      r_req_ovf <= 1'b0;
    end else begin
      if (w_term && w_fail)  r_bus_err <= 1'b1;
      else if (i_err_clr)    r_bus_err <= 1'b0;
      if (w_buf_ovf)         r_req_ovf <= 1'b1;
      else if (i_err_clr)    r_req_ovf <= 1'b0;
    end
  end

  assign o_wb_cyc   = r_cyc;
  assign o_wb_stb   = r_cyc;
  assign o_wb_we    = r_we;
  assign o_wb_adr   = r_adr;
  assign o_wb_dat_o = r_dat_o;
  assign o_wb_sel   = r_cyc ? 4'hF : 4'h0;
  assign o_rsp_vld  = r_rsp_vld;
  assign o_rsp_dat  = r_rsp_dat;
  assign o_bus_err  = r_bus_err;
  assign o_req_ovf  = r_req_ovf;
  assign o_busy     = ~w_idle | w_buf_full;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// tb/tb_spi_wb_bridge.sv - directed self-checking bench for spi_wb_bridge
module tb_spi_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_we;
  logic [23:0] req_adr;
  logic [31:0] req_dat;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, err_clr;
  logic        bus_err, req_ovf, busy;

  int errors = 0;
  int checks = 0;
  int n;
  logic flag;

  always #5 clk = ~clk;

  spi_wb_bridge dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_vld  (req_vld),
    .i_req_we   (req_we),
    .i_req_adr  (req_adr),
    .i_req_dat  (req_dat),
    .o_rsp_vld  (rsp_vld),
    .i_rsp_rdy  (rsp_rdy),
    .o_rsp_dat  (rsp_dat),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_adr   (wb_adr),
    .o_wb_dat_o (wb_dat_o),
    .o_wb_sel   (wb_sel),
    .i_wb_dat_i (wb_dat_i),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err),
    .i_err_clr  (err_clr),
    .o_bus_err  (bus_err),
    .o_req_ovf  (req_ovf),
    .o_busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [23:0] adr, input logic [31:0] dat);
    req_vld = 1'b1; req_we = we; req_adr = adr; req_dat = dat;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic ack_once();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic accept_rsp();
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_vld = 0; req_we = 0; req_adr = '0; req_dat = '0;
    rsp_rdy = 0; wb_dat_i = '0; wb_ack = 0; wb_err = 0; err_clr = 0;
    tick(); tick(); tick();
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_flags", {bus_err, req_ovf, busy}, 0);
    rst = 1'b0;
    tick();

    // 1: posted write, ack after two wait cycles
    req(1'b1, 24'h000010, 32'h11223344);
    chk("w1_cyc", {wb_cyc, wb_stb, wb_we}, 3'b111);
    chk("w1_sel", wb_sel, 4'hF);
    chk("w1_adr", wb_adr, 24'h000010);
    chk("w1_dat", wb_dat_o, 32'h11223344);
    tick(); tick();
    chk("w1_wait_cyc", wb_cyc, 1);
    ack_once();
    chk("w1_end_cyc", wb_cyc, 0);
    chk("w1_no_rsp", rsp_vld, 0);
    chk("w1_idle", busy, 0);

    // 2: read with upstream stalled for 5 cycles
    req(1'b0, 24'h000020, 32'h0);
    chk("r2_cyc_we", {wb_cyc, wb_we}, 2'b10);
    chk("r2_adr", wb_adr, 24'h000020);
    wb_dat_i = 32'hCAFEF00D;
    ack_once();
    chk("r2_cyc_drop", wb_cyc, 0);
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(rsp_vld === 1'b1 && rsp_dat === 32'hCAFEF00D)) flag = 1'b0;
      tick();
    end
    chk("r2_rsp_held", flag, 1);
    chk("r2_rsp_dat", rsp_dat, 32'hCAFEF00D);
    accept_rsp();
    chk("r2_rsp_done", rsp_vld, 0);
    chk("r2_idle", busy, 0);

    // 3: read timeout
    req(1'b0, 24'h000030, 32'h0);
    n = (wb_cyc === 1'b1) ? 1 : 0;
    for (int i = 0; i < 400 && wb_cyc === 1'b1; i++) begin
      tick();
      if (wb_cyc === 1'b1) n++;
    end
    chk("t3_cyc_len", n, 255);
    chk("t3_rsp_vld", rsp_vld, 1);
    chk("t3_rsp_dat", rsp_dat, 32'hDEADBEEF);
    chk("t3_bus_err", bus_err, 1);
    accept_rsp();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr", bus_err, 0);

    // 4: three back-to-back writes while bus stalled
    req_vld = 1'b1; req_we = 1'b1;
    req_adr = 24'h0; req_dat = 32'hA0; tick();
    chk("b4_adr0", wb_adr, 24'h0);
    req_adr = 24'h1; req_dat = 32'hA1; tick();
    req_adr = 24'h2; req_dat = 32'hA2; tick();
    req_vld = 1'b0;
    chk("b4_ovf", req_ovf, 1);
    chk("b4_still_adr0", {wb_cyc, wb_adr}, {1'b1, 24'h0});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("b4_ovf_clr", req_ovf, 0);
    ack_once();
    chk("b4_adr0_done", wb_cyc, 0);
    chk("b4_busy_buf", busy, 1);
    req_vld = 1'b1; req_adr = 24'h3; req_dat = 32'hA3; tick();
    req_vld = 1'b0;
    chk("b4_adr1", {wb_cyc, wb_adr}, {1'b1, 24'h1});
    chk("b4_dat1", wb_dat_o, 32'hA1);
    chk("b4_no_drop", req_ovf, 0);
    ack_once();
    chk("b4_adr1_done", wb_cyc, 0);
    tick();
    chk("b4_adr3", {wb_cyc, wb_adr}, {1'b1, 24'h3});
    chk("b4_dat3", wb_dat_o, 32'hA3);
    ack_once();
    flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (wb_cyc !== 1'b0) flag = 1'b0;
      tick();
    end
    chk("b4_no_adr2", flag, 1);
    chk("b4_idle", busy, 0);

    // 5: ack and err together
    req(1'b0, 24'h000040, 32'h0);
    wb_dat_i = 32'h12345678;
    wb_ack = 1'b1; wb_err = 1'b1; tick(); wb_ack = 1'b0; wb_err = 1'b0;
    chk("e5_rsp_vld", rsp_vld, 1);
    chk("e5_rsp_dat", rsp_dat, 32'hDEADBEEF);
    chk("e5_bus_err", bus_err, 1);
    accept_rsp();
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // 6: reset with cycle in flight and buffer full
    req_vld = 1'b1; req_we = 1'b1;
    req_adr = 24'h50; req_dat = 32'hB0; tick();
    req_adr = 24'h51; req_dat = 32'hB1; tick();
    req_vld = 1'b0;
    chk("r6_pre", {wb_cyc, busy}, 2'b11);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("r6_cyc", {wb_cyc, wb_stb}, 2'b00);
    chk("r6_outs", {rsp_vld, bus_err, req_ovf, busy, wb_sel}, 0);
    tick(); tick();
    chk("r6_buf_empty", {wb_cyc, busy}, 2'b00);
    req(1'b1, 24'h000060, 32'h600D600D);
    chk("r6_new_cyc", {wb_cyc, wb_we, wb_adr}, {2'b11, 24'h60});
    chk("r6_new_dat", wb_dat_o, 32'h600D600D);
    ack_once();
    chk("r6_new_done", {wb_cyc, rsp_vld, busy}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
